// File: rtl/ddr_cmd_decoder.sv
// Receive-side DDR command/address bus decoder.
// The bus is captured into the _p0 registers. Commands are decoded from that
// registered copy and presented one clock later. The decoder also keeps a
// per-rank/bank open-row table with tRCD/tRP down-counters, captures MRS/EMRS
// values, and records sticky protocol and timing violations.
module ddr_cmd_decoder #(
    parameter int T_RCD = 2,
    parameter int T_RP  = 2,
    parameter int T_MRD = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  ddr_cke,
    input  logic [1:0]  ddr_cs_n,
    input  logic        ddr_ras_n,
    input  logic        ddr_cas_n,
    input  logic        ddr_we_n,
    input  logic [12:0] ddr_addr,
    input  logic [1:0]  ddr_ba,
    output logic        cmd_valid,
    output logic [3:0]  cmd_code,
    output logic [1:0]  cmd_rank,
    output logic [24:0] cmd_addr,
    output logic        auto_pre,
    output logic [12:0] mode_reg,
    output logic [12:0] ext_mode_reg,
    output logic [7:0]  err_flags,
    output logic [15:0] err_count
);

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] RCD_LD = CNT_W'(T_RCD - 1);
    localparam logic [CNT_W-1:0] RP_LD  = CNT_W'(T_RP - 1);
    localparam logic [CNT_W-1:0] MRD_LD = CNT_W'(T_MRD - 1);

    localparam logic [3:0] EV_NOP      = 4'd0;
    localparam logic [3:0] EV_ACT      = 4'd1;
    localparam logic [3:0] EV_READ     = 4'd2;
    localparam logic [3:0] EV_WRITE    = 4'd3;
    localparam logic [3:0] EV_PRE      = 4'd4;
    localparam logic [3:0] EV_PREALL   = 4'd5;
    localparam logic [3:0] EV_AREF     = 4'd6;
    localparam logic [3:0] EV_SREF     = 4'd7;
    localparam logic [3:0] EV_MRS      = 4'd8;
    localparam logic [3:0] EV_EMRS     = 4'd9;
    localparam logic [3:0] EV_PWRDN    = 4'd10;
    localparam logic [3:0] EV_CKE_EXIT = 4'd11;
    localparam logic [3:0] EV_ILLEGAL  = 4'd15;

    // Down-counter step: holds at zero once expired.
    function automatic logic [CNT_W-1:0] cnt_dec(input logic [CNT_W-1:0] c);
        return (c == '0) ? '0 : c - 1'b1;
    endfunction

    // Saturating increment for the violation counter.
    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    // Sampled bus (_p0) and the cke sample before it (_p1).
    logic [1:0]  cke_p0;
    logic [1:0]  cke_p1;
    logic [1:0]  cs_n_p0;
    logic [2:0]  strb_p0;
    logic [12:0] addr_p0;
    logic [1:0]  ba_p0;

    // Bank table and the mode-register timer.
    logic [3:0]       open_q [2];
    logic [12:0]      row_q  [2][4];
    logic [CNT_W-1:0] trcd_q [2][4];
    logic [CNT_W-1:0] trp_q  [2][4];
    logic [CNT_W-1:0] mrd_q;

    logic [3:0]       open_d [2];
    logic [12:0]      row_d  [2][4];
    logic [CNT_W-1:0] trcd_d [2][4];
    logic [CNT_W-1:0] trp_d  [2][4];
    logic [CNT_W-1:0] mrd_d;
    logic [12:0]      mode_d;
    logic [12:0]      ext_d;

    logic [3:0]  ev_code;
    logic [1:0]  ev_rank;
    logic [24:0] ev_addr;
    logic        ev_ap;
    logic [7:0]  err_new;
    logic [1:0]  rise;
    logic [1:0]  fall;
    logic [1:0]  sel;
    logic [1:0]  tgt;
    logic        bcast;
    logic        ridx;

    // Capture the command bus and keep the previous cke sample.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cke_p0  <= 2'b00;
            cke_p1  <= 2'b00;
            cs_n_p0 <= 2'b11;
            strb_p0 <= 3'b111;
            addr_p0 <= '0;
            ba_p0   <= '0;
        end else begin
            cke_p0  <= ddr_cke;
            cke_p1  <= cke_p0;
            cs_n_p0 <= ddr_cs_n;
            strb_p0 <= {ddr_ras_n, ddr_cas_n, ddr_we_n};
            addr_p0 <= ddr_addr;
            ba_p0   <= ddr_ba;
        end
    end

    // Decode the sampled command and check it against the pre-edge bank table.
    always_comb begin
        ev_code = EV_NOP;
        ev_rank = 2'b00;
        ev_addr = '0;
        ev_ap   = 1'b0;
        err_new = '0;
        open_d  = open_q;
        row_d   = row_q;
        for (int r = 0; r < 2; r++) begin
            for (int b = 0; b < 4; b++) begin
                trcd_d[r][b] = cnt_dec(trcd_q[r][b]);
                trp_d[r][b]  = cnt_dec(trp_q[r][b]);
            end
        end
        mrd_d  = cnt_dec(mrd_q);
        mode_d = mode_reg;
        ext_d  = ext_mode_reg;

        rise  = ~cke_p1 & cke_p0;
        fall  = cke_p1 & ~cke_p0;
        sel   = ~cs_n_p0;
        tgt   = sel & cke_p0;
        bcast = (cs_n_p0 == 2'b00);
        ridx  = (tgt == 2'b10);

        if (rise != 2'b00) begin
            ev_code = EV_CKE_EXIT;
            ev_rank = rise;
        end else if (fall != 2'b00) begin
            if (sel != 2'b00 && strb_p0 == 3'b001) begin
                ev_code = EV_SREF;
                ev_rank = sel;
                for (int r = 0; r < 2; r++)
                    if (sel[r] && open_q[r] != 4'b0000) err_new[4] = 1'b1;
            end else if (sel == 2'b00 || strb_p0 == 3'b111) begin
                ev_code = EV_PWRDN;
                ev_rank = fall;
            end else begin
                ev_code    = EV_ILLEGAL;
                ev_rank    = sel;
                err_new[7] = 1'b1;
            end
        end else if (tgt != 2'b00 && strb_p0 != 3'b111) begin
            // Ranks whose cke stayed low are dropped from the target set.
            ev_rank = tgt;
            case (strb_p0)
                3'b011: begin
                    ev_code = EV_ACT;
                    ev_addr = {addr_p0, 12'd0};
                    if (bcast) err_new[6] = 1'b1;
                    for (int r = 0; r < 2; r++) begin
                        if (tgt[r]) begin
                            if (open_q[r][ba_p0]) err_new[1] = 1'b1;
                            if (trp_q[r][ba_p0] != '0) err_new[3] = 1'b1;
                            if (!bcast) begin
                                open_d[r][ba_p0] = 1'b1;
                                row_d[r][ba_p0]  = addr_p0;
                                trcd_d[r][ba_p0] = RCD_LD;
                            end
                        end
                    end
                end
                3'b101, 3'b100: begin
                    ev_code = (strb_p0 == 3'b101) ? EV_READ : EV_WRITE;
                    ev_ap   = addr_p0[10];
                    ev_addr = {row_q[ridx][ba_p0], ridx, ba_p0, addr_p0[8:0]};
                    if (bcast) err_new[6] = 1'b1;
                    for (int r = 0; r < 2; r++) begin
                        if (tgt[r]) begin
                            if (!open_q[r][ba_p0]) err_new[0] = 1'b1;
                            if (trcd_q[r][ba_p0] != '0) err_new[2] = 1'b1;
                            if (!bcast && addr_p0[10]) begin
                                open_d[r][ba_p0] = 1'b0;
                                trp_d[r][ba_p0]  = RP_LD;
                            end
                        end
                    end
                end
                3'b010: begin
                    ev_code = addr_p0[10] ? EV_PREALL : EV_PRE;
                    for (int r = 0; r < 2; r++) begin
                        for (int b = 0; b < 4; b++) begin
                            if (tgt[r] && (addr_p0[10] || 2'(b) == ba_p0)) begin
                                open_d[r][b] = 1'b0;
                                trp_d[r][b]  = RP_LD;
                            end
                        end
                    end
                end
                3'b001: begin
                    ev_code = EV_AREF;
                    for (int r = 0; r < 2; r++)
                        if (tgt[r] && open_q[r] != 4'b0000) err_new[4] = 1'b1;
                end
                3'b000: begin
                    case (ba_p0)
                        2'b00: begin
                            ev_code = EV_MRS;
                            mode_d  = addr_p0;
                            mrd_d   = MRD_LD;
                        end
                        2'b01: begin
                            ev_code = EV_EMRS;
                            ext_d   = addr_p0;
                            mrd_d   = MRD_LD;
                        end
                        default: begin
                            ev_code    = EV_ILLEGAL;
                            err_new[7] = 1'b1;
                        end
                    endcase
                end
                default: begin
                    ev_code    = EV_ILLEGAL;
                    err_new[7] = 1'b1;
                end
            endcase
        end

        if (ev_code != EV_NOP && mrd_q != '0) err_new[5] = 1'b1;
    end

    // Bank table and mode-register timer update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mrd_q <= '0;
            for (int r = 0; r < 2; r++) begin
                open_q[r] <= 4'b0000;
                for (int b = 0; b < 4; b++) begin
                    row_q[r][b]  <= '0;
                    trcd_q[r][b] <= '0;
                    trp_q[r][b]  <= '0;
                end
            end
        end else begin
            mrd_q  <= mrd_d;
            open_q <= open_d;
            row_q  <= row_d;
            trcd_q <= trcd_d;
            trp_q  <= trp_d;
        end
    end

    // Output stage: event pulse, mode registers, and error bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd_valid    <= 1'b0;
            cmd_code     <= '0;
            cmd_rank     <= '0;
            cmd_addr     <= '0;
            auto_pre     <= 1'b0;
            mode_reg     <= '0;
            ext_mode_reg <= '0;
            err_flags    <= '0;
            err_count    <= '0;
        end else begin
            cmd_valid    <= (ev_code != EV_NOP);
            cmd_code     <= ev_code;
            cmd_rank     <= ev_rank;
            cmd_addr     <= ev_addr;
            auto_pre     <= ev_ap;
            mode_reg     <= mode_d;
            ext_mode_reg <= ext_d;
            err_flags    <= err_flags | err_new;
            if (err_new != 8'h00) err_count <= sat_inc(err_count);
        end
    end

endmodule

// File: tb/tb_ddr_cmd_decoder.sv
// Testbench for ddr_cmd_decoder. Expected events go into a queue together
// with the cycle they are due. They are taken off the queue as the decoder
// pulses cmd_valid.
module tb_ddr_cmd_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  ddr_cke;
    logic [1:0]  ddr_cs_n;
    logic        ddr_ras_n;
    logic        ddr_cas_n;
    logic        ddr_we_n;
    logic [12:0] ddr_addr;
    logic [1:0]  ddr_ba;
    logic        cmd_valid;
    logic [3:0]  cmd_code;
    logic [1:0]  cmd_rank;
    logic [24:0] cmd_addr;
    logic        auto_pre;
    logic [12:0] mode_reg;
    logic [12:0] ext_mode_reg;
    logic [7:0]  err_flags;
    logic [15:0] err_count;

    ddr_cmd_decoder #(.T_RCD(2), .T_RP(2), .T_MRD(2)) dut (
        .clk(clk), .rst_n(rst_n), .ddr_cke(ddr_cke), .ddr_cs_n(ddr_cs_n),
        .ddr_ras_n(ddr_ras_n), .ddr_cas_n(ddr_cas_n), .ddr_we_n(ddr_we_n),
        .ddr_addr(ddr_addr), .ddr_ba(ddr_ba), .cmd_valid(cmd_valid),
        .cmd_code(cmd_code), .cmd_rank(cmd_rank), .cmd_addr(cmd_addr),
        .auto_pre(auto_pre), .mode_reg(mode_reg), .ext_mode_reg(ext_mode_reg),
        .err_flags(err_flags), .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  code;
        logic [1:0]  rank;
        logic [24:0] addr;
        logic        ap;
        logic [31:0] due;
    } ev_t;

    ev_t sb_q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;

    localparam logic [2:0] S_ACT = 3'b011, S_RD = 3'b101, S_WR = 3'b100,
                           S_PRE = 3'b010, S_REF = 3'b001, S_MRS = 3'b000,
                           S_NOP = 3'b111;

    // Advance one clock, then score any event the decoder produced.
    task automatic tick();
        ev_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (cmd_valid === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event cyc=%0d code=%0d rank=%b addr=%h", cyc, cmd_code, cmd_rank, cmd_addr);
            end else begin
                e = sb_q.pop_front();
                if ({cmd_code, cmd_rank, cmd_addr, auto_pre} !== {e.code, e.rank, e.addr, e.ap} || cyc != int'(e.due)) begin
                    errors++;
                    $display("FAIL event got code=%0d rank=%b addr=%h ap=%b cyc=%0d expected code=%0d rank=%b addr=%h ap=%b cyc=%0d",
                             cmd_code, cmd_rank, cmd_addr, auto_pre, cyc, e.code, e.rank, e.addr, e.ap, e.due);
                end
            end
        end else if (sb_q.size() != 0 && int'(sb_q[0].due) <= cyc) begin
            checks++;
            errors++;
            e = sb_q.pop_front();
            $display("FAIL missing_event cyc=%0d got cmd_valid=%b expected code=%0d rank=%b", cyc, cmd_valid, e.code, e.rank);
        end
    endtask

    task automatic bus(input logic [1:0] cke, input logic [1:0] cs, input logic [2:0] strb,
                       input logic [12:0] a, input logic [1:0] b);
        ddr_cke  = cke;
        ddr_cs_n = cs;
        {ddr_ras_n, ddr_cas_n, ddr_we_n} = strb;
        ddr_addr = a;
        ddr_ba   = b;
    endtask

    // Queue the event that the command currently on the bus should produce.
    task automatic expect_ev(input logic [3:0] c, input logic [1:0] r, input logic [24:0] a, input logic ap);
        ev_t e;
        e.code = c;
        e.rank = r;
        e.addr = a;
        e.ap   = ap;
        e.due  = 32'(cyc + 2);
        sb_q.push_back(e);
    endtask

    task automatic idle(input int n, input logic [1:0] cke);
        for (int i = 0; i < n; i++) begin
            bus(cke, 2'b11, S_NOP, 13'd0, 2'd0);
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus(2'b00, 2'b11, S_NOP, 13'd0, 2'd0);
        tick();
        tick();
        checks++;
        if ({cmd_valid, cmd_code, cmd_rank, cmd_addr, auto_pre} !== 33'd0) begin
            errors++;
            $display("FAIL reset_cmd got valid=%b code=%0d rank=%b addr=%h ap=%b expected all zero", cmd_valid, cmd_code, cmd_rank, cmd_addr, auto_pre);
        end
        checks++;
        if (mode_reg !== 13'd0 || ext_mode_reg !== 13'd0) begin
            errors++;
            $display("FAIL reset_mode got %h %h expected 0 0", mode_reg, ext_mode_reg);
        end
        checks++;
        if (err_flags !== 8'h00 || err_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_err got flags=%h count=%0d expected 00 0", err_flags, err_count);
        end
        rst_n = 1'b1;
        idle(3, 2'b00);
    endtask

    task automatic test_cke_exit();
        bus(2'b11, 2'b11, S_NOP, 13'd0, 2'd0);
        expect_ev(4'd11, 2'b11, 25'd0, 1'b0);
        tick();
        idle(3, 2'b11);
        checks++;
        if (err_flags !== 8'h00) begin
            errors++;
            $display("FAIL cke_exit_err got flags=%h expected 00", err_flags);
        end
    endtask

    task automatic test_act_read();
        bus(2'b11, 2'b01, S_ACT, 13'h1ABC, 2'd2);
        expect_ev(4'd1, 2'b10, {13'h1ABC, 12'd0}, 1'b0);
        tick();
        idle(1, 2'b11);
        bus(2'b11, 2'b01, S_RD, 13'h00F3, 2'd2);
        expect_ev(4'd2, 2'b10, {13'h1ABC, 1'b1, 2'b10, 9'h0F3}, 1'b0);
        tick();
        idle(3, 2'b11);
        checks++;
        if (err_flags !== 8'h00 || err_count !== 16'd0) begin
            errors++;
            $display("FAIL act_read_err got flags=%h count=%0d expected 00 0", err_flags, err_count);
        end
    endtask

    task automatic test_trcd();
        bus(2'b11, 2'b10, S_ACT, 13'h0055, 2'd0);
        expect_ev(4'd1, 2'b01, {13'h0055, 12'd0}, 1'b0);
        tick();
        bus(2'b11, 2'b10, S_RD, 13'h0010, 2'd0);
        expect_ev(4'd2, 2'b01, {13'h0055, 1'b0, 2'b00, 9'h010}, 1'b0);
        tick();
        idle(3, 2'b11);
        checks++;
        if (err_flags !== 8'h04 || err_count !== 16'd1) begin
            errors++;
            $display("FAIL trcd_err got flags=%h count=%0d expected 04 1", err_flags, err_count);
        end
    endtask

    task automatic test_closed_open();
        bus(2'b11, 2'b10, S_WR, 13'h0001, 2'd3);
        expect_ev(4'd3, 2'b01, {13'h0000, 1'b0, 2'b11, 9'h001}, 1'b0);
        tick();
        bus(2'b11, 2'b01, S_ACT, 13'h0777, 2'd2);
        expect_ev(4'd1, 2'b10, {13'h0777, 12'd0}, 1'b0);
        tick();
        idle(3, 2'b11);
        checks++;
        if (err_flags !== 8'h07 || err_count !== 16'd3) begin
            errors++;
            $display("FAIL closed_open_err got flags=%h count=%0d expected 07 3", err_flags, err_count);
        end
    endtask

    task automatic test_trp();
        bus(2'b11, 2'b10, S_WR, 13'h0405, 2'd0);
        expect_ev(4'd3, 2'b01, {13'h0055, 1'b0, 2'b00, 9'h005}, 1'b1);
        tick();
        bus(2'b11, 2'b10, S_ACT, 13'h0100, 2'd0);
        expect_ev(4'd1, 2'b01, {13'h0100, 12'd0}, 1'b0);
        tick();
        idle(3, 2'b11);
        checks++;
        if (err_flags !== 8'h0F || err_count !== 16'd4) begin
            errors++;
            $display("FAIL trp_short_err got flags=%h count=%0d expected 0F 4", err_flags, err_count);
        end
        bus(2'b11, 2'b10, S_ACT, 13'h0200, 2'd1);
        expect_ev(4'd1, 2'b01, {13'h0200, 12'd0}, 1'b0);
        tick();
        idle(1, 2'b11);
        bus(2'b11, 2'b10, S_WR, 13'h0406, 2'd1);
        expect_ev(4'd3, 2'b01, {13'h0200, 1'b0, 2'b01, 9'h006}, 1'b1);
        tick();
        idle(1, 2'b11);
        bus(2'b11, 2'b10, S_ACT, 13'h0201, 2'd1);
        expect_ev(4'd1, 2'b01, {13'h0201, 12'd0}, 1'b0);
        tick();
        idle(3, 2'b11);
        checks++;
        if (err_count !== 16'd4) begin
            errors++;
            $display("FAIL trp_ok_count got %0d expected 4", err_count);
        end
    endtask

    task automatic test_mrs_sref();
        bus(2'b11, 2'b00, S_PRE, 13'h0400, 2'd0);
        expect_ev(4'd5, 2'b11, 25'd0, 1'b0);
        tick();
        idle(2, 2'b11);
        bus(2'b11, 2'b00, S_MRS, 13'h0022, 2'd0);
        expect_ev(4'd8, 2'b11, 25'd0, 1'b0);
        tick();
        bus(2'b11, 2'b00, S_REF, 13'h0000, 2'd0);
        expect_ev(4'd6, 2'b11, 25'd0, 1'b0);
        tick();
        idle(3, 2'b11);
        checks++;
        if (mode_reg !== 13'h022) begin
            errors++;
            $display("FAIL mrs_value got %h expected 022", mode_reg);
        end
        checks++;
        if (err_flags !== 8'h2F || err_count !== 16'd5) begin
            errors++;
            $display("FAIL mrd_err got flags=%h count=%0d expected 2F 5", err_flags, err_count);
        end
        bus(2'b11, 2'b10, S_MRS, 13'h00A5, 2'd1);
        expect_ev(4'd9, 2'b01, 25'd0, 1'b0);
        tick();
        idle(3, 2'b11);
        checks++;
        if (ext_mode_reg !== 13'h0A5 || mode_reg !== 13'h022) begin
            errors++;
            $display("FAIL emrs_value got ext=%h mode=%h expected 0A5 022", ext_mode_reg, mode_reg);
        end
        bus(2'b00, 2'b00, S_REF, 13'h0000, 2'd0);
        expect_ev(4'd7, 2'b11, 25'd0, 1'b0);
        tick();
        idle(1, 2'b00);
        bus(2'b00, 2'b10, S_ACT, 13'h0123, 2'd0);
        tick();
        idle(2, 2'b00);
        bus(2'b11, 2'b11, S_NOP, 13'h0000, 2'd0);
        expect_ev(4'd11, 2'b11, 25'd0, 1'b0);
        tick();
        idle(3, 2'b11);
        checks++;
        if (err_count !== 16'd5) begin
            errors++;
            $display("FAIL sref_count got %0d expected 5", err_count);
        end
    endtask

    task automatic test_broadcast_illegal();
        bus(2'b11, 2'b00, S_ACT, 13'h0333, 2'd2);
        expect_ev(4'd1, 2'b11, {13'h0333, 12'd0}, 1'b0);
        tick();
        idle(2, 2'b11);
        bus(2'b11, 2'b10, S_RD, 13'h0007, 2'd2);
        expect_ev(4'd2, 2'b01, {13'h0000, 1'b0, 2'b10, 9'h007}, 1'b0);
        tick();
        idle(3, 2'b11);
        checks++;
        if (err_flags !== 8'h6F || err_count !== 16'd7) begin
            errors++;
            $display("FAIL bcast_err got flags=%h count=%0d expected 6F 7", err_flags, err_count);
        end
        bus(2'b11, 2'b10, S_MRS, 13'h0011, 2'd2);
        expect_ev(4'd15, 2'b01, 25'd0, 1'b0);
        tick();
        bus(2'b11, 2'b01, 3'b110, 13'h0000, 2'd0);
        expect_ev(4'd15, 2'b10, 25'd0, 1'b0);
        tick();
        idle(3, 2'b11);
        checks++;
        if (err_flags !== 8'hEF || err_count !== 16'd9 || mode_reg !== 13'h022) begin
            errors++;
            $display("FAIL illegal_err got flags=%h count=%0d mode=%h expected EF 9 022", err_flags, err_count, mode_reg);
        end
    endtask

    task automatic test_powerdown();
        bus(2'b10, 2'b11, S_NOP, 13'h0000, 2'd0);
        expect_ev(4'd10, 2'b01, 25'd0, 1'b0);
        tick();
        bus(2'b11, 2'b11, S_NOP, 13'h0000, 2'd0);
        expect_ev(4'd11, 2'b01, 25'd0, 1'b0);
        tick();
        idle(3, 2'b11);
        checks++;
        if (err_count !== 16'd9) begin
            errors++;
            $display("FAIL pwrdn_count got %0d expected 9", err_count);
        end
    endtask

    task automatic test_back_to_back();
        bus(2'b11, 2'b10, S_ACT, 13'h00A0, 2'd2);
        expect_ev(4'd1, 2'b01, {13'h00A0, 12'd0}, 1'b0);
        tick();
        bus(2'b11, 2'b10, S_ACT, 13'h00B0, 2'd3);
        expect_ev(4'd1, 2'b01, {13'h00B0, 12'd0}, 1'b0);
        tick();
        bus(2'b11, 2'b01, S_ACT, 13'h00C0, 2'd3);
        expect_ev(4'd1, 2'b10, {13'h00C0, 12'd0}, 1'b0);
        tick();
        bus(2'b11, 2'b10, S_RD, 13'h0011, 2'd2);
        expect_ev(4'd2, 2'b01, {13'h00A0, 1'b0, 2'b10, 9'h011}, 1'b0);
        tick();
        bus(2'b11, 2'b10, S_RD, 13'h0012, 2'd3);
        expect_ev(4'd2, 2'b01, {13'h00B0, 1'b0, 2'b11, 9'h012}, 1'b0);
        tick();
        bus(2'b11, 2'b01, S_WR, 13'h01FF, 2'd3);
        expect_ev(4'd3, 2'b10, {13'h00C0, 1'b1, 2'b11, 9'h1FF}, 1'b0);
        tick();
        idle(3, 2'b11);
        checks++;
        if (err_count !== 16'd9) begin
            errors++;
            $display("FAIL b2b_count got %0d expected 9", err_count);
        end
    endtask

    task automatic test_reset_mid();
        bus(2'b11, 2'b10, S_ACT, 13'h0F00, 2'd0);
        tick();
        rst_n = 1'b0;
        bus(2'b11, 2'b11, S_NOP, 13'h0000, 2'd0);
        tick();
        checks++;
        if (cmd_valid !== 1'b0 || err_count !== 16'd0 || err_flags !== 8'h00 || mode_reg !== 13'd0 || ext_mode_reg !== 13'd0) begin
            errors++;
            $display("FAIL mid_reset got valid=%b count=%0d flags=%h mode=%h ext=%h expected 0 0 00 0 0",
                     cmd_valid, err_count, err_flags, mode_reg, ext_mode_reg);
        end
        rst_n = 1'b1;
        idle(2, 2'b00);
        bus(2'b11, 2'b11, S_NOP, 13'h0000, 2'd0);
        expect_ev(4'd11, 2'b11, 25'd0, 1'b0);
        tick();
        idle(1, 2'b11);
        bus(2'b11, 2'b10, S_RD, 13'h0000, 2'd1);
        expect_ev(4'd2, 2'b01, {13'h0000, 1'b0, 2'b01, 9'h000}, 1'b0);
        tick();
        idle(3, 2'b11);
        checks++;
        if (err_flags !== 8'h01 || err_count !== 16'd1) begin
            errors++;
            $display("FAIL post_reset_err got flags=%h count=%0d expected 01 1", err_flags, err_count);
        end
    endtask

    initial begin
        bus(2'b00, 2'b11, S_NOP, 13'd0, 2'd0);
        test_reset();
        test_cke_exit();
        test_act_read();
        test_trcd();
        test_closed_open();
        test_trp();
        test_mrs_sref();
        test_broadcast_illegal();
        test_powerdown();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL pending_events got %0d expected 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
